// File: rtl/mc_pkg.sv
// Shared types and helpers for the missionary/cannibal move controller.
// The move limit is controlled by MC_MOVE_LIMIT_EN in river_crossing_ctrl.sv.
package mc_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      APPLY = 3'd2,
      EVAL  = 3'd3,
      WON   = 3'd4,
      LOST  = 3'd5
   } mc_state_e;

   localparam int MC_DEF_N        = 3;
   localparam int MC_DEF_BOAT_CAP = 2;
   // Counts are widened to this width before they reach bank_unsafe.
   localparam int MC_FW           = 4;

   function automatic logic bank_unsafe(input logic [MC_FW-1:0] m, input logic [MC_FW-1:0] c);
      return (m != '0) && (c > m);
   endfunction

endpackage

// File: rtl/mc_move_checker.sv
// Combinational legality check of a boat load, and the left-bank counts that
// result if the load crosses from the current boat side.
module mc_move_checker
   import mc_pkg::*;
#(
   parameter int N        = MC_DEF_N,
   parameter int BOAT_CAP = MC_DEF_BOAT_CAP,
   parameter int CW       = $clog2(N + 1)
) (
   input  logic [CW-1:0] load_m_i,
   input  logic [CW-1:0] load_c_i,
   input  logic [CW-1:0] bank_m_i,
   input  logic [CW-1:0] bank_c_i,
   input  logic          boat_side_i,
   output logic          legal_o,
   output logic [CW-1:0] next_m_o,
   output logic [CW-1:0] next_c_o
);

   localparam logic [CW-1:0] N_W   = CW'(N);
   localparam logic [CW:0]   CAP_W = (CW + 1)'(BOAT_CAP);

   logic [CW:0]   load_sum;
   logic [CW-1:0] avail_m;
   logic [CW-1:0] avail_c;

   always_comb begin
      load_sum = {1'b0, load_m_i} + {1'b0, load_c_i};
      // People available to board are those on the bank where the boat sits.
      avail_m  = boat_side_i ? (N_W - bank_m_i) : bank_m_i;
      avail_c  = boat_side_i ? (N_W - bank_c_i) : bank_c_i;
      legal_o  = (load_sum != '0) && (load_sum <= CAP_W) &&
                 (load_m_i <= avail_m) && (load_c_i <= avail_c);
      next_m_o = boat_side_i ? (bank_m_i + load_m_i) : (bank_m_i - load_m_i);
      next_c_o = boat_side_i ? (bank_c_i + load_c_i) : (bank_c_i - load_c_i);
   end

endmodule

// File: rtl/river_crossing_ctrl.sv
// Interactive move controller for the river-crossing puzzle: FSM plus bank registers.
// Define MC_MOVE_LIMIT_EN to lose the game when move_count reaches MAX_MOVES.
module river_crossing_ctrl
   import mc_pkg::*;
#(
   parameter  int N         = MC_DEF_N,
   parameter  int BOAT_CAP  = MC_DEF_BOAT_CAP,
   parameter  int MAX_MOVES = 15,
   localparam int CW        = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          restart,
   input  logic          move_valid,
   input  logic [CW-1:0] move_m,
   input  logic [CW-1:0] move_c,
   output logic          move_ready,
   output logic          reject,
   output logic [CW-1:0] missionary_left,
   output logic [CW-1:0] cannibal_left,
   output logic          boat_side,
   output logic [4:0]    move_count,
   output logic          win,
   output logic          lose,
   output logic [2:0]    dbg_state
);

   // Handshake: a load is taken on any rising edge where move_valid and
   // move_ready are both high; move_ready is high only in IDLE.

`ifdef MC_MOVE_LIMIT_EN
   localparam logic LIMIT_EN = 1'b1;
`else
   localparam logic LIMIT_EN = 1'b0;
`endif

   localparam logic [CW-1:0] N_W       = CW'(N);
   localparam logic [4:0]    LIMIT_CNT = 5'(MAX_MOVES);

   mc_state_e     state_q;
   logic [CW-1:0] load_m_q, load_c_q;
   logic [CW-1:0] ml_q, cl_q;
   logic          boat_q;
   logic [4:0]    count_q;
   logic          win_q, lose_q, reject_q;

   logic          legal;
   logic [CW-1:0] next_m, next_c;
   logic          any_unsafe;
   logic          limit_hit;

   mc_move_checker #(
      .N        (N),
      .BOAT_CAP (BOAT_CAP),
      .CW       (CW)
   ) u_checker (
      .load_m_i    (load_m_q),
      .load_c_i    (load_c_q),
      .bank_m_i    (ml_q),
      .bank_c_i    (cl_q),
      .boat_side_i (boat_q),
      .legal_o     (legal),
      .next_m_o    (next_m),
      .next_c_o    (next_c)
   );

   assign any_unsafe = bank_unsafe(MC_FW'(ml_q), MC_FW'(cl_q)) ||
                       bank_unsafe(MC_FW'(N_W - ml_q), MC_FW'(N_W - cl_q));
   assign limit_hit  = LIMIT_EN && (count_q == LIMIT_CNT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         load_m_q <= '0;
         load_c_q <= '0;
         ml_q     <= N_W;
         cl_q     <= N_W;
         boat_q   <= 1'b0;
         count_q  <= '0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
         reject_q <= 1'b0;
      end else if (restart) begin
         state_q  <= IDLE;
         load_m_q <= '0;
         load_c_q <= '0;
         ml_q     <= N_W;
         cl_q     <= N_W;
         boat_q   <= 1'b0;
         count_q  <= '0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         reject_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (move_valid) begin
                  load_m_q <= move_m;
                  load_c_q <= move_c;
                  state_q  <= CHECK;
               end
            end
            CHECK: begin
               if (!legal) begin
                  reject_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  state_q  <= APPLY;
               end
            end
            APPLY: begin
               ml_q   <= next_m;
               cl_q   <= next_c;
               boat_q <= ~boat_q;
               if (count_q != 5'd31) count_q <= count_q + 5'd1;
               state_q <= EVAL;
            end
            EVAL: begin
               // A win outranks both an unsafe bank and the move limit.
               if (ml_q == '0 && cl_q == '0) begin
                  win_q   <= 1'b1;
                  state_q <= WON;
               end else if (any_unsafe || limit_hit) begin
                  lose_q  <= 1'b1;
                  state_q <= LOST;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= state_q;
         endcase
      end
   end

   assign move_ready      = (state_q == IDLE);
   assign reject          = reject_q;
   assign missionary_left = ml_q;
   assign cannibal_left   = cl_q;
   assign boat_side       = boat_q;
   assign move_count      = count_q;
   assign win             = win_q;
   assign lose            = lose_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Self-checking bench for river_crossing_ctrl: directed puzzle scenarios plus
// randomized play compared every cycle against a rule-level model.
module tb_river_crossing_ctrl;

   localparam int N   = 3;
   localparam int CAP = 2;
   localparam int CW  = 2;
`ifdef MC_MOVE_LIMIT_EN
   localparam int MAXM = 4;
`else
   localparam int MAXM = 15;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          restart = 1'b0;
   logic          move_valid = 1'b0;
   logic [CW-1:0] move_m = '0;
   logic [CW-1:0] move_c = '0;
   logic          move_ready, reject, boat_side, win, lose;
   logic [CW-1:0] missionary_left, cannibal_left;
   logic [4:0]    move_count;
   logic [2:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;

   river_crossing_ctrl #(.N(N), .BOAT_CAP(CAP), .MAX_MOVES(MAXM)) dut (
      .clk             (clk),
      .reset           (reset),
      .restart         (restart),
      .move_valid      (move_valid),
      .move_m          (move_m),
      .move_c          (move_c),
      .move_ready      (move_ready),
      .reject          (reject),
      .missionary_left (missionary_left),
      .cannibal_left   (cannibal_left),
      .boat_side       (boat_side),
      .move_count      (move_count),
      .win             (win),
      .lose            (lose),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks a request by cycles elapsed since its acceptance edge.
   int m_ml, m_cl, m_side, m_cnt, m_age, m_lm, m_lc;
   bit m_win, m_lose, m_rej, m_legal;

   function automatic bit rule_legal(int m, int c, int side, int ml, int cl);
      int am, ac;
      if (m + c == 0 || m + c > CAP) return 1'b0;
      am = side ? N - ml : ml;
      ac = side ? N - cl : cl;
      return (m <= am) && (c <= ac);
   endfunction

   function automatic bit unsafe(int m, int c);
      return (m > 0) && (c > m);
   endfunction

   task automatic model_init();
      m_ml = N; m_cl = N; m_side = 0; m_cnt = 0; m_age = -1;
      m_win = 0; m_lose = 0; m_rej = 0; m_legal = 0; m_lm = 0; m_lc = 0;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset || restart) begin
         model_init();
      end else begin
         m_rej = 0;
         if (m_age < 0) begin
            if (move_valid && !m_win && !m_lose) begin
               m_age = 0; m_lm = move_m; m_lc = move_c;
               m_legal = rule_legal(m_lm, m_lc, m_side, m_ml, m_cl);
            end
         end else begin
            m_age++;
            if (m_age == 1 && !m_legal) begin
               m_rej = 1; m_age = -1;
            end else if (m_age == 2) begin
               m_ml = m_side ? m_ml + m_lm : m_ml - m_lm;
               m_cl = m_side ? m_cl + m_lc : m_cl - m_lc;
               m_side = 1 - m_side;
               m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
            end else if (m_age == 3) begin
               if (m_ml == 0 && m_cl == 0) m_win = 1;
               else if (unsafe(m_ml, m_cl) || unsafe(N - m_ml, N - m_cl)) m_lose = 1;
`ifdef MC_MOVE_LIMIT_EN
               else if (m_cnt == MAXM) m_lose = 1;
`endif
               m_age = -1;
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_ready", move_ready, (m_age < 0) && !m_win && !m_lose);
         chk("cyc_reject", reject, m_rej);
         chk("cyc_ml", missionary_left, m_ml);
         chk("cyc_cl", cannibal_left, m_cl);
         chk("cyc_side", boat_side, m_side);
         chk("cyc_count", move_count, m_cnt);
         chk("cyc_win", win, m_win);
         chk("cyc_lose", lose, m_lose);
      end
   end

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic send(input int m, input int c, input int hold);
      int w = 0;
      while (!move_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!move_ready) chk("ready_timeout", move_ready, 1);
      move_m = CW'(m);
      move_c = CW'(c);
      move_valid = 1'b1;
      repeat (hold) @(negedge clk);
      move_valid = 1'b0;
   endtask

   task automatic mv(input int m, input int c);
      send(m, c, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic chk_initial(input string tag);
      chk({tag, "_ml"}, missionary_left, 3);
      chk({tag, "_cl"}, cannibal_left, 3);
      chk({tag, "_side"}, boat_side, 0);
      chk({tag, "_count"}, move_count, 0);
      chk({tag, "_ready"}, move_ready, 1);
      chk({tag, "_win"}, win, 0);
      chk({tag, "_lose"}, lose, 0);
   endtask

   // ---------------- stimulus ----------------
   int sol_m[11] = '{0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0};
   int sol_c[11] = '{2, 1, 2, 1, 0, 1, 0, 1, 2, 1, 2};
   int lm_tab[5] = '{1, 0, 1, 2, 0};
   int lc_tab[5] = '{0, 1, 1, 0, 2};

   initial begin
      #2 reset = 1'b0;
      @(negedge clk);
      cmp_en = 1'b1;
      chk_initial("in_reset");
      chk("in_reset_reject", reject, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_initial("after_reset");

      // Legal 0M/2C from the start.
      send(0, 2, 1);
      @(negedge clk); chk("m02_no_reject", reject, 0);
      @(negedge clk);
      chk("m02_cl", cannibal_left, 1);
      chk("m02_side", boat_side, 1);
      chk("m02_count", move_count, 1);
      @(negedge clk);
      chk("m02_ready", move_ready, 1);
      chk("m02_lose", lose, 0);

      // Illegal loads: empty, over capacity, more than the boat's bank holds.
      pulse_restart();
      send(0, 0, 1);
      @(negedge clk); chk("ill00_reject", reject, 1); chk("ill00_ready", move_ready, 1);
      @(negedge clk); chk("ill00_pulse_end", reject, 0); chk("ill00_count", move_count, 0);
      send(2, 1, 1);
      @(negedge clk); chk("ill21_reject", reject, 1);
      @(negedge clk); chk("ill21_ml", missionary_left, 3); chk("ill21_cl", cannibal_left, 3);
      mv(0, 2);
      send(1, 0, 1);
      @(negedge clk); chk("ill10r_reject", reject, 1);
      @(negedge clk);
      chk("ill10r_count", move_count, 1);
      chk("ill10r_cl", cannibal_left, 1);
      chk("ill10r_side", boat_side, 1);

      // Losing move 2M/0C, then ignored requests, then restart.
      pulse_restart();
      mv(2, 0);
      chk("lose_ml", missionary_left, 1);
      chk("lose_cl", cannibal_left, 3);
      chk("lose_flag", lose, 1);
      chk("lose_ready", move_ready, 0);
      move_m = 2'd1; move_c = 2'd0; move_valid = 1'b1;
      repeat (4) @(negedge clk);
      move_valid = 1'b0;
      chk("lose_ignored_ml", missionary_left, 1);
      chk("lose_ignored_count", move_count, 1);
      chk("lose_still_ready0", move_ready, 0);
      pulse_restart();
      chk_initial("lose_restart");

      // Standard 11-move solution.
      for (int i = 0; i < 11; i++) if (!win && !lose) mv(sol_m[i], sol_c[i]);
`ifdef MC_MOVE_LIMIT_EN
      chk("sol_limit_lose", lose, 1);
      chk("sol_limit_count", move_count, 4);
`else
      chk("sol_ml", missionary_left, 0);
      chk("sol_cl", cannibal_left, 0);
      chk("sol_side", boat_side, 1);
      chk("sol_count", move_count, 11);
      chk("sol_win", win, 1);
`endif

      // Shuttle 0M/1C back and forth.
      pulse_restart();
`ifdef MC_MOVE_LIMIT_EN
      for (int i = 0; i < 3; i++) mv(0, 1);
      chk("limit_3_lose", lose, 0);
      mv(0, 1);
      chk("limit_4_lose", lose, 1);
      chk("limit_4_count", move_count, 4);
`else
      for (int i = 0; i < 32; i++) mv(0, 1);
      chk("sat_count", move_count, 31);
      chk("sat_lose", lose, 0);
      chk("sat_cl", cannibal_left, 3);
`endif

      // Restart while in CHECK, for an illegal and a legal load.
      pulse_restart();
      send(0, 0, 1);
      pulse_restart();
      chk("rst_check_no_reject", reject, 0);
      @(negedge clk); chk("rst_check_no_reject2", reject, 0);
      send(0, 2, 1);
      pulse_restart();
      repeat (3) @(negedge clk);
      chk_initial("rst_check_legal");

      // Asynchronous reset in the middle of a move.
      send(0, 2, 1);
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      chk_initial("async_rst");
      reset = 1'b1;
      @(negedge clk);

      // Randomized play.
      for (int it = 0; it < 400; it++) begin
         if (win || lose || $urandom_range(0, 15) == 0) pulse_restart();
         begin
            int k, m, c;
            k = $urandom_range(0, 4);
            m = lm_tab[k];
            c = lc_tab[k];
            if ($urandom_range(0, 3) == 0) begin
               m = $urandom_range(0, 3);
               c = $urandom_range(0, 3);
            end
            send(m, c, $urandom_range(1, 3));
         end
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pulse_restart();
            repeat (2) @(negedge clk);
         end else if ($urandom_range(0, 39) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
         end else begin
            repeat ($urandom_range(3, 5)) @(negedge clk);
         end
      end

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
